// File: rtl/blk_stat_buffer_if.sv
// Pixel-side bundle for blk_stat_buffer: pixel stream and thresholds in, per-block flags out.
// AW mirrors the accumulator width derived inside the buffer from PXS and VW.
interface blk_stat_buffer_if #(
    parameter int NCH = 3,
    parameter int VW  = 9,
    parameter int PXS = 900
);
    localparam int AW = $clog2(PXS * (2**VW - 1) + 1);

    logic                 de;
    logic                 h_save;
    logic                 v_save;
    logic [NCH*VW-1:0]    val;
    logic [NCH*AW-1:0]    thr;
    logic [NCH*AW-1:0]    hys;
    logic [NCH-1:0]       flag;
    logic                 frame_done;

    modport master (
        output de, h_save, v_save, val, thr, hys,
        input  flag, frame_done
    );

    modport slave (
        input  de, h_save, v_save, val, thr, hys,
        output flag, frame_done
    );
endinterface

// File: rtl/blk_stat_buffer.sv
// Per-block statistics buffer: accumulates NCH channels over HBLKS x VBLKS blocks,
// thresholds each block sum and replays last frame's flags. Hysteresis is built when BLK_STAT_HYS_EN is defined.
module blk_stat_buffer #(
    parameter int HBLKS = 10,
    parameter int VBLKS = 10,
    parameter int NCH   = 3,
    parameter int VW    = 9,
    parameter int PXS   = 900
) (
    input  logic             clk_i,
    input  logic             rst_i,
    blk_stat_buffer_if.slave bus
);
    localparam int AW = $clog2(PXS * (2**VW - 1) + 1);
    localparam int HW = (HBLKS > 1) ? $clog2(HBLKS) : 1;
    localparam int RW = (VBLKS > 1) ? $clog2(VBLKS) : 1;

    typedef logic [AW-1:0] acc_t;
    typedef logic [AW+1:0] wide_t;

    localparam acc_t AMAX = '1;

    // Clamp a widened sum back into the accumulator range instead of wrapping.
    function automatic acc_t sat_acc(input wide_t a);
        return (a > {2'b00, AMAX}) ? AMAX : a[AW-1:0];
    endfunction

    logic [HW-1:0]   hcol;
    logic [RW-1:0]   vrow;
    logic            first_line;
    logic            frame_done_q;
    logic [NCH-1:0]  flag_q;

    acc_t            lacc [NCH];
    acc_t            bacc [HBLKS][NCH];
    logic [NCH-1:0]  rb   [HBLKS];
    logic [NCH-1:0]  mem  [VBLKS][HBLKS];

    logic            hs_eff;
    logic            hcol_last;
    logic            vrow_last;
    acc_t            lacc_nxt [NCH];
    acc_t            sum      [NCH];
    logic [NCH-1:0]  d;

    assign hs_eff    = bus.de & bus.h_save;
    assign hcol_last = (hcol == HW'(HBLKS - 1));
    assign vrow_last = (vrow == RW'(VBLKS - 1));

`ifndef BLK_STAT_HYS_EN
    logic unused_hys;
    assign unused_hys = ^bus.hys;
`endif

    always_comb begin
        wide_t          pix;
        wide_t          base;
        acc_t           thr_k;
        acc_t           limit;
`ifdef BLK_STAT_HYS_EN
        acc_t           hys_k;
        logic [AW:0]    hi_w;
        acc_t           hi;
        acc_t           lo;
        logic [NCH-1:0] prev;
`endif
        pix   = '0;
        base  = '0;
        thr_k = '0;
        limit = '0;
        d     = '0;
`ifdef BLK_STAT_HYS_EN
        hys_k = '0;
        hi_w  = '0;
        hi    = '0;
        lo    = '0;
        prev  = mem[vrow][hcol];
`endif
        for (int k = 0; k < NCH; k++) begin
            pix  = {{(AW + 2 - VW){1'b0}}, bus.val[k*VW +: VW]};
            base = first_line ? '0 : {2'b00, bacc[hcol][k]};

            // Line accumulator only carries within a valid run of one block column.
            lacc_nxt[k] = (bus.de && !bus.h_save) ? sat_acc({2'b00, lacc[k]} + pix) : '0;
            sum[k]      = sat_acc(base + {2'b00, lacc[k]} + pix);

            thr_k = bus.thr[k*AW +: AW];
`ifdef BLK_STAT_HYS_EN
            hys_k = bus.hys[k*AW +: AW];
            hi_w  = {1'b0, thr_k} + {1'b0, hys_k};
            hi    = hi_w[AW] ? AMAX : hi_w[AW-1:0];
            lo    = (thr_k > hys_k) ? (thr_k - hys_k) : '0;
            // A block lit last frame needs less to stay lit, and vice versa.
            limit = prev[k] ? lo : hi;
`else
            limit = thr_k;
`endif
            d[k] = (sum[k] >= limit);
        end
    end

    // NOTE: the block-sum, row-buffer and decision arrays are reset with the datapath so a
    // mid-frame reset cannot leak stale flags into the next frame; they are small flop arrays.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcol         <= '0;
            vrow         <= '0;
            first_line   <= 1'b1;
            frame_done_q <= 1'b0;
            flag_q       <= '0;
            for (int k = 0; k < NCH; k++) begin
                lacc[k] <= '0;
            end
            for (int c = 0; c < HBLKS; c++) begin
                rb[c] <= '0;
                for (int k = 0; k < NCH; k++) begin
                    bacc[c][k] <= '0;
                end
            end
            for (int r = 0; r < VBLKS; r++) begin
                for (int c = 0; c < HBLKS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else begin
            flag_q       <= mem[vrow][hcol];
            frame_done_q <= bus.v_save && vrow_last;

            for (int k = 0; k < NCH; k++) begin
                lacc[k] <= lacc_nxt[k];
            end

            if (hs_eff) begin
                for (int k = 0; k < NCH; k++) begin
                    bacc[hcol][k] <= sum[k];
                end
                rb[hcol] <= d;
                if (hcol_last) begin
                    hcol       <= '0;
                    first_line <= 1'b0;
                end else begin
                    hcol <= hcol + 1'b1;
                end
            end

            // Row commit wins over the column advance; a coincident h_save lands in the row.
            if (bus.v_save) begin
                hcol       <= '0;
                first_line <= 1'b1;
                vrow       <= vrow_last ? '0 : vrow + 1'b1;
                for (int c = 0; c < HBLKS; c++) begin
                    mem[vrow][c] <= (hs_eff && (c == int'(hcol))) ? d : rb[c];
                end
            end
        end
    end

    assign bus.flag       = flag_q;
    assign bus.frame_done = frame_done_q;

endmodule
